// File: rtl/rps_pkg.sv
// Shared encodings, colours, FSM state type and the round judging helper
// for the rock-paper-scissors round sequencer.
package rps_pkg;

   // Choice encodings, shared by user input, computer input and ROM select
   localparam logic [1:0] ROCK    = 2'b00;
   localparam logic [1:0] SCISSOR = 2'b01;
   localparam logic [1:0] PAPER   = 2'b10;
   localparam logic [1:0] INVALID = 2'b11;

   // Round result encodings
   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_USER = 2'b01;
   localparam logic [1:0] RES_COM  = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   // Pixel colours: foreground, and the per-panel background
   localparam logic [2:0] FG      = 3'b111;
   localparam logic [2:0] BG_USER = 3'b010;
   localparam logic [2:0] BG_COM  = 3'b100;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      JUDGE,
      DRAW_U,
      DRAW_C,
      DRAIN,
      DONE
   } state_t;

   // True when choice a beats choice b
   function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
      return ((a == ROCK)    && (b == SCISSOR)) ||
             ((a == SCISSOR) && (b == PAPER))   ||
             ((a == PAPER)   && (b == ROCK));
   endfunction

endpackage

// File: rtl/rps_pixel_scanner.sv
// Raster scanner for one panel: px runs fastest, py slowest, and a linear
// address tracks py*PANEL_W+px. Clear restarts the scan; at the last pixel
// the counters hold so the final address stays on the ROM port.
module rps_pixel_scanner
#(
   parameter int PANEL_W = 80,
   parameter int PANEL_H = 60
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        enable,
   output logic [7:0]  px,
   output logic [6:0]  py,
   output logic [12:0] addr,
   output logic        last
);

   localparam logic [7:0] PX_LAST = 8'(PANEL_W - 1);
   localparam logic [6:0] PY_LAST = 7'(PANEL_H - 1);

   // Last-pixel flag, used by the controller to switch panels
   always_comb begin
      last = (px == PX_LAST) && (py == PY_LAST);
   end

   // Scan counters; address increments in step since px is the inner loop
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         px   <= '0;
         py   <= '0;
         addr <= '0;
      end else if (enable && !last) begin
         addr <= addr + 13'd1;
         if (px == PX_LAST) begin
            px <= '0;
            py <= py + 7'd1;
         end else begin
            px <= px + 8'd1;
         end
      end
   end

endmodule

// File: rtl/rps_round_sequencer.sv
// Round controller: latches choices on go, judges the round, updates the
// saturating scores, then scans the user panel followed by the computer
// panel through the shared ROM and the single VGA plot port.
module rps_round_sequencer
   import rps_pkg::*;
#(
   parameter int PANEL_W  = 80,
   parameter int PANEL_H  = 60,
   parameter int PANEL_Y0 = 30,
   parameter int ROM_LAT  = 1,
   parameter int SCORE_W  = 8
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   input  logic               go,
   input  logic [1:0]         user_choice,
   input  logic [1:0]         com_choice,
   output logic [12:0]        rom_addr,
   output logic [1:0]         rom_sel,
   input  logic               rom_q,
   output logic [7:0]         vga_x,
   output logic [6:0]         vga_y,
   output logic [2:0]         vga_colour,
   output logic               vga_plot,
   output logic [SCORE_W-1:0] user_score,
   output logic [SCORE_W-1:0] com_score,
   output logic [1:0]         com_shown,
   output logic [1:0]         result,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT - 1);

   state_t state;
   state_t state_next;

   logic [1:0] u_lat;
   logic [1:0] drain_cnt;

   // Scanner control and stage-0 pixel descriptors
   logic        scan_clear;
   logic        scan_enable;
   logic [7:0]  scan_px;
   logic [6:0]  scan_py;
   logic        scan_last;
   logic        pix_valid;
   logic        pix_com;
   logic [7:0]  pix_x;
   logic [6:0]  pix_y;

   // Delay line aligning coordinates with the ROM read data
   logic [7:0] x_pipe     [ROM_LAT];
   logic [6:0] y_pipe     [ROM_LAT];
   logic       valid_pipe [ROM_LAT];
   logic       com_pipe   [ROM_LAT];

   rps_pixel_scanner #(
      .PANEL_W (PANEL_W),
      .PANEL_H (PANEL_H)
   ) u_scanner (
      .clk     (CLOCK_50),
      .reset_n (reset_n),
      .clear   (scan_clear),
      .enable  (scan_enable),
      .px      (scan_px),
      .py      (scan_py),
      .addr    (rom_addr),
      .last    (scan_last)
   );

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; go only matters in IDLE
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (go) state_next = LATCH;
         LATCH:   state_next = (user_choice == INVALID) ? DONE : JUDGE;
         JUDGE:   state_next = DRAW_U;
         DRAW_U:  if (scan_last) state_next = DRAW_C;
         DRAW_C:  if (scan_last) state_next = DRAIN;
         DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs and scanner control
   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      scan_enable = (state == DRAW_U) || (state == DRAW_C);
      pix_valid   = scan_enable;
      pix_com     = (state == DRAW_C);
      // Restart before the user panel and again at the panel handover
      scan_clear  = (state == JUDGE) || ((state == DRAW_U) && scan_last);
      pix_x       = pix_com ? (8'(PANEL_W) + scan_px) : scan_px;
      pix_y       = 7'(PANEL_Y0) + scan_py;
   end

   // Latch both choices; an invalid computer choice is shown as rock
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         u_lat     <= ROCK;
         com_shown <= ROCK;
      end else if (state == LATCH) begin
         u_lat     <= user_choice;
         com_shown <= (com_choice == INVALID) ? ROCK : com_choice;
      end
   end

   // Judge the round and bump the winner's score, saturating at all-ones
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         result     <= RES_NONE;
         user_score <= '0;
         com_score  <= '0;
      end else if ((state == LATCH) && (user_choice == INVALID)) begin
         result <= RES_NONE;
      end else if (state == JUDGE) begin
         if (beats(u_lat, com_shown)) begin
            result <= RES_USER;
            if (user_score != '1) user_score <= user_score + 1'b1;
         end else if (u_lat == com_shown) begin
            result <= RES_DRAW;
         end else begin
            result <= RES_COM;
            if (com_score != '1) com_score <= com_score + 1'b1;
         end
      end
   end

   // Image select follows the panel being scanned and holds afterwards
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         rom_sel <= ROCK;
      end else if (state == JUDGE) begin
         rom_sel <= u_lat;
      end else if ((state == DRAW_U) && scan_last) begin
         rom_sel <= com_shown;
      end
   end

   // Drain counter lets the last ROM reads reach the plot port
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n || (state != DRAIN)) begin
         drain_cnt <= '0;
      end else begin
         drain_cnt <= drain_cnt + 2'd1;
      end
   end

   // Pixel delay line, ROM_LAT stages deep
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            x_pipe[i]     <= '0;
            y_pipe[i]     <= '0;
            valid_pipe[i] <= 1'b0;
            com_pipe[i]   <= 1'b0;
         end
      end else begin
         x_pipe[0]     <= pix_x;
         y_pipe[0]     <= pix_y;
         valid_pipe[0] <= pix_valid;
         com_pipe[0]   <= pix_com;
         for (int i = 1; i < ROM_LAT; i++) begin
            x_pipe[i]     <= x_pipe[i-1];
            y_pipe[i]     <= y_pipe[i-1];
            valid_pipe[i] <= valid_pipe[i-1];
            com_pipe[i]   <= com_pipe[i-1];
         end
      end
   end

   // Plot port driven from the end of the delay line; colour is black when idle
   always_comb begin
      vga_x    = x_pipe[ROM_LAT-1];
      vga_y    = y_pipe[ROM_LAT-1];
      vga_plot = valid_pipe[ROM_LAT-1];
      if (!vga_plot) begin
         vga_colour = 3'b000;
      end else if (rom_q) begin
         vga_colour = FG;
      end else begin
         vga_colour = com_pipe[ROM_LAT-1] ? BG_COM : BG_USER;
      end
   end

endmodule
